// File: rtl/button_events_pkg.sv
// button_events_pkg: shared state type, sizing helpers and constants.
// Optional feature macro: BUTTON_EVENTS_REPEAT_EN (auto-repeat).
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int RCNT_W = 8;
  localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

  function automatic int ms_cyc(input int clk_freq);
    return clk_freq / 1000;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the millisecond counter shared by hold and repeat timing.
  function automatic int ms_cnt_w(input int hold_ms, input int repeat_ms);
    return $clog2(max2(hold_ms, repeat_ms) + 1);
  endfunction

  // Width of the prescaler counting 0..n-1.
  function automatic int ps_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [RCNT_W-1:0] sat_inc(
    input logic [RCNT_W-1:0] v
  );
    return (v == RCNT_MAX) ? v : v + RCNT_W'(1);
  endfunction

endpackage

// File: rtl/button_events_if.sv
// button_events_if: button level in, UI event outputs.
// master drives the level, slave is the event generator.
interface button_events_if
  import button_events_pkg::*;
();

  logic              level_i;
  logic              press_o;
  logic              release_o;
  logic              held_o;
  logic              repeat_o;
  logic [RCNT_W-1:0] repeat_count_o;

  modport master (
    output level_i,
    input  press_o,
    input  release_o,
    input  held_o,
    input  repeat_o,
    input  repeat_count_o
  );

  modport slave (
    input  level_i,
    output press_o,
    output release_o,
    output held_o,
    output repeat_o,
    output repeat_count_o
  );

endinterface

// File: rtl/button_events_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler with synchronous clear.
// tick_o is high for the cycle the count sits on its terminal value.
module ms_tick_gen
  import button_events_pkg::*;
#(
  parameter int MS_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = ps_w(MS_CYC);
  localparam logic [W-1:0] LAST = W'(MS_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/button_events.sv
// button_events: press/release pulses, long-hold flag, auto-repeat.
// Auto-repeat is built only with BUTTON_EVENTS_REPEAT_EN defined.
module button_events
  import button_events_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic            clk,
  input  logic            reset_n,
  button_events_if.slave  bus
);

  localparam int MS_CYC = ms_cyc(CLK_FREQ);
  localparam int MS_W   = ms_cnt_w(HOLD_MS, REPEAT_MS);
  localparam logic [MS_W-1:0] HOLD_LAST = MS_W'(HOLD_MS - 1);

  if ((CLK_FREQ % 1000) != 0) begin : g_bad_freq
    $fatal(1, "button_events: CLK_FREQ not a multiple of 1000");
  end
  if (HOLD_MS < 1 || REPEAT_MS < 1) begin : g_bad_ms
    $fatal(1, "button_events: HOLD_MS and REPEAT_MS must be >= 1");
  end

  state_t          state_q;
  logic            level_q;
  logic            rise;
  logic            fall;
  logic [MS_W-1:0] ms_q;
  logic            press_q;
  logic            release_q;
  logic            held_q;
  logic            tick;
  logic            ps_clr;
  logic            ps_en;

  assign rise = bus.level_i & ~level_q;
  assign fall = ~bus.level_i & level_q;

  assign ps_clr = (state_q == IDLE) & rise;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam logic [MS_W-1:0] REP_LAST = MS_W'(REPEAT_MS - 1);
  logic              repeat_q;
  logic [RCNT_W-1:0] rcnt_q;
  assign ps_en = (state_q != IDLE);
`else
  assign ps_en = (state_q == PRESSED);
`endif

  ms_tick_gen #(
    .MS_CYC (MS_CYC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr_i  (ps_clr),
    .en_i   (ps_en),
    .tick_o (tick)
  );

  // Edge-detect register for the button level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= bus.level_i;
    end
  end

  // Event FSM; release beats a same-cycle timer expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ms_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      repeat_q  <= 1'b0;
      rcnt_q    <= '0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
            ms_q    <= '0;
`ifdef BUTTON_EVENTS_REPEAT_EN
            rcnt_q  <= '0;
`endif
          end
        end
        PRESSED: begin
          if (fall) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
          end else if (tick) begin
            if (ms_q == HOLD_LAST) begin
              state_q  <= HELD;
              held_q   <= 1'b1;
              ms_q     <= '0;
`ifdef BUTTON_EVENTS_REPEAT_EN
              repeat_q <= 1'b1;
              rcnt_q   <= sat_inc(rcnt_q);
`endif
            end else begin
              ms_q <= ms_q + MS_W'(1);
            end
          end
        end
        HELD: begin
          if (fall) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (tick) begin
            if (ms_q == REP_LAST) begin
              repeat_q <= 1'b1;
              rcnt_q   <= sat_inc(rcnt_q);
              ms_q     <= '0;
            end else begin
              ms_q <= ms_q + MS_W'(1);
            end
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
  assign bus.held_o    = held_q;
`ifdef BUTTON_EVENTS_REPEAT_EN
  assign bus.repeat_o       = repeat_q;
  assign bus.repeat_count_o = rcnt_q;
`else
  assign bus.repeat_o       = 1'b0;
  assign bus.repeat_count_o = '0;
`endif

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed self-checking bench for button_events.
// MS_CYC=100, HOLD_CYC=500, REPEAT_CYC=200 at a 10 ns clock.
module tb_button_events;

  logic clk;
  logic reset_n;

  button_events_if bus();

  button_events #(
    .CLK_FREQ  (100000),
    .HOLD_MS   (5),
    .REPEAT_MS (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int cyc;
  int n_press, n_rel, n_rep;
  int t_press, t_rel, t_held, t_hfall;
  int rep_t[$];
  logic prev_held;

  task automatic clear_mon();
    n_press = 0; n_rel = 0; n_rep = 0;
    t_press = -1; t_rel = -1; t_held = -1; t_hfall = -1;
    rep_t.delete();
    prev_held = bus.held_o;
  endtask

  // Advance one edge and sample 1 ns later, logging events.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.press_o) begin n_press++; t_press = cyc; end
      if (bus.release_o) begin n_rel++; t_rel = cyc; end
      if (bus.repeat_o) begin n_rep++; rep_t.push_back(cyc); end
      if (bus.held_o && !prev_held && t_held < 0) t_held = cyc;
      if (!bus.held_o && prev_held) t_hfall = cyc;
      prev_held = bus.held_o;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.level_i = 1'b0;
    #23;
    n_cmp++;
    if (bus.press_o !== 1'b0 || bus.release_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b%b want 00",
               bus.press_o, bus.release_o);
    end
    n_cmp++;
    if (bus.held_o !== 1'b0 || bus.repeat_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held_rep: got %b%b want 00",
               bus.held_o, bus.repeat_o);
    end
    n_cmp++;
    if (bus.repeat_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", bus.repeat_count_o);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_mon();
    step(20);
    n_cmp++;
    if (n_press !== 0 || n_rel !== 0) begin
      n_err++;
      $display("FAIL idle_quiet: got press=%0d rel=%0d want 0/0",
               n_press, n_rel);
    end
  endtask

  task automatic test_short_press();
    int c0;
    clear_mon();
    c0 = cyc;
    bus.level_i = 1'b1;
    step(300);
    bus.level_i = 1'b0;
    step(50);
    n_cmp++;
    if (n_press !== 1 || t_press !== c0 + 1) begin
      n_err++;
      $display("FAIL short_press: got n=%0d t=%0d want n=1 t=%0d",
               n_press, t_press, c0 + 1);
    end
    n_cmp++;
    if (n_rel !== 1 || t_rel !== c0 + 301) begin
      n_err++;
      $display("FAIL short_release: got n=%0d t=%0d want n=1 t=%0d",
               n_rel, t_rel, c0 + 301);
    end
    n_cmp++;
    if (t_held !== -1 || n_rep !== 0) begin
      n_err++;
      $display("FAIL short_no_hold: got held_t=%0d rep=%0d want -1/0",
               t_held, n_rep);
    end
  endtask

  task automatic test_long_hold();
    clear_mon();
    bus.level_i = 1'b1;
    step(1000);
    n_cmp++;
    if (t_held !== t_press + 500) begin
      n_err++;
      $display("FAIL long_held_t: got %0d want %0d",
               t_held, t_press + 500);
    end
`ifdef BUTTON_EVENTS_REPEAT_EN
    n_cmp++;
    if (n_rep !== 3) begin
      n_err++;
      $display("FAIL long_rep_n: got %0d want 3", n_rep);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (rep_t[k] !== t_press + 500 + 200 * k) begin
          n_err++;
          $display("FAIL long_rep_t%0d: got %0d want %0d", k,
                   rep_t[k], t_press + 500 + 200 * k);
        end
      end
    end
    n_cmp++;
    if (bus.repeat_count_o !== 8'd3) begin
      n_err++;
      $display("FAIL long_count: got %0d want 3", bus.repeat_count_o);
    end
`else
    n_cmp++;
    if (n_rep !== 0 || bus.repeat_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL norep: got rep=%0d cnt=%0d want 0/0",
               n_rep, bus.repeat_count_o);
    end
`endif
    bus.level_i = 1'b0;
    step(10);
    n_cmp++;
    if (t_rel !== t_press + 1000 || t_hfall !== t_rel) begin
      n_err++;
      $display("FAIL long_release: got rel=%0d hfall=%0d want %0d",
               t_rel, t_hfall, t_press + 1000);
    end
`ifdef BUTTON_EVENTS_REPEAT_EN
    n_cmp++;
    if (bus.repeat_count_o !== 8'd3) begin
      n_err++;
      $display("FAIL long_count_kept: got %0d want 3",
               bus.repeat_count_o);
    end
`endif
  endtask

  task automatic test_race();
    clear_mon();
    bus.level_i = 1'b1;
    step(500);
    bus.level_i = 1'b0;
    step(20);
    n_cmp++;
    if (t_rel !== t_press + 500 || n_rel !== 1) begin
      n_err++;
      $display("FAIL race_release: got t=%0d n=%0d want t=%0d n=1",
               t_rel, n_rel, t_press + 500);
    end
    n_cmp++;
    if (t_held !== -1 || n_rep !== 0) begin
      n_err++;
      $display("FAIL race_no_hold: got held_t=%0d rep=%0d want -1/0",
               t_held, n_rep);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    bus.level_i = 1'b1;
    step(10);
    bus.level_i = 1'b0;
    step(1);
    bus.level_i = 1'b1;
    step(1);
    n_cmp++;
    if (n_press !== 2 || n_rel !== 1 || t_press !== t_rel + 1) begin
      n_err++;
      $display("FAIL b2b: got p=%0d r=%0d tp=%0d tr=%0d want 2/1/tr+1",
               n_press, n_rel, t_press, t_rel);
    end
`ifdef BUTTON_EVENTS_REPEAT_EN
    n_cmp++;
    if (bus.repeat_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_count_clr: got %0d want 0", bus.repeat_count_o);
    end
`endif
    bus.level_i = 1'b0;
    step(5);
  endtask

`ifdef BUTTON_EVENTS_REPEAT_EN
  task automatic test_saturation();
    clear_mon();
    bus.level_i = 1'b1;
    step(51600);
    n_cmp++;
    if (bus.repeat_count_o !== 8'd255 || n_rep !== 256) begin
      n_err++;
      $display("FAIL sat: got cnt=%0d rep=%0d want 255/256",
               bus.repeat_count_o, n_rep);
    end
    bus.level_i = 1'b0;
    step(5);
    n_cmp++;
    if (bus.repeat_count_o !== 8'd255) begin
      n_err++;
      $display("FAIL sat_kept: got %0d want 255", bus.repeat_count_o);
    end
    bus.level_i = 1'b1;
    step(1);
    n_cmp++;
    if (bus.press_o !== 1'b1 || bus.repeat_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL sat_clear: got p=%b cnt=%0d want 1/0",
               bus.press_o, bus.repeat_count_o);
    end
    bus.level_i = 1'b0;
    step(5);
  endtask
`endif

  task automatic test_reset_mid_hold();
    clear_mon();
    bus.level_i = 1'b1;
    step(600);
    n_cmp++;
    if (bus.held_o !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre_held: got %b want 1", bus.held_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.press_o, bus.release_o, bus.held_o, bus.repeat_o}
        !== 4'b0000 || bus.repeat_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_async: got %b%b%b%b cnt=%0d want 0000 0",
               bus.press_o, bus.release_o, bus.held_o, bus.repeat_o,
               bus.repeat_count_o);
    end
    step(3);
    reset_n = 1'b1;
    clear_mon();
    step(1);
    n_cmp++;
    if (n_press !== 1 || t_press !== cyc) begin
      n_err++;
      $display("FAIL midrst_press: got n=%0d t=%0d want n=1 t=%0d",
               n_press, t_press, cyc);
    end
    bus.level_i = 1'b0;
    step(5);
    n_cmp++;
    if (n_rel !== 1 || bus.held_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_release: got n=%0d held=%b want 1/0",
               n_rel, bus.held_o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_race();
    test_back_to_back();
`ifdef BUTTON_EVENTS_REPEAT_EN
    test_saturation();
`endif
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Converts the debounced, clk-synchronous button level from the debouncer into discrete user-interface events: a one-cycle press pulse, a one-cycle release pulse, a long-hold flag, and auto-repeat pulses while held. Sits between the debounce stage and the NCO control logic, so frequency/phase step commands see exactly one event per press and a controlled repeat rate on long holds.

## Interface
- CLK_FREQ, 100000000: clk frequency in Hz; must be a multiple of 1000 (elaboration-time check, fatal otherwise).
- HOLD_MS, 500: time level must stay high before `held` asserts; ≥1.
- REPEAT_MS, 100: period between auto-repeat pulses once held; ≥1.
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- level  in  1  debounced button level, already synchronous to clk; 1 = pressed.
- press  out  1  one-cycle pulse on each press.
- release  out  1  one-cycle pulse on each release.
- held  out  1  high from long-hold detection until release.
- repeat  out  1  one-cycle auto-repeat pulse while held.
- repeat_count  out  8  repeat pulses since last press, saturating at 255.

## Operation
- Derived constants: MS_CYC = CLK_FREQ/1000; HOLD_CYC = HOLD_MS*MS_CYC; REPEAT_CYC = REPEAT_MS*MS_CYC.
- level registered into level_q (reset 0); rise = level & ~level_q, fall = ~level & level_q.
- FSM states: IDLE, PRESSED, HELD.
- IDLE: on rise → PRESSED, pulse press, clear ms prescaler and ms counter, clear repeat_count.
- PRESSED: ms counter counts ms ticks; on fall → IDLE, pulse release; on reaching HOLD_MS → HELD, set held, pulse repeat (REPEAT_EN), restart counter.
- HELD: on fall → IDLE, pulse release, clear held; on counter reaching REPEAT_MS → pulse repeat, increment repeat_count (saturate 255), restart counter.
- fall and timer expiry in the same cycle: fall wins; no held/repeat that cycle.
- level high at reset deassertion: treated as a fresh press (press pulse).
- repeat_count holds its value after release; cleared only by next press or reset.
- Reset mid-operation: all outputs 0 immediately; state IDLE; counters 0.

## Timing
- Reset values: press=0, release=0, held=0, repeat=0, repeat_count=0.
- press rises on the clk edge after level is first sampled high (latency 1); release likewise for low.
- held and first repeat rise exactly HOLD_CYC cycles after press rises; subsequent repeats every REPEAT_CYC cycles.
- held falls in the same cycle release pulses.
- All pulses exactly one cycle; press and release never coincide.
- All outputs registered; no combinational input→output path.

## Configuration
- BUTTON_EVENTS_REPEAT_EN defined: auto-repeat behaviour as above.
- Undefined: repeat tied 0, repeat_count tied 0, HELD has no repeat timer (counter idles); held still asserts after HOLD_CYC.

## Structure
- button_events_pkg: state enum typedef, ms_cyc() function, counter-width localparams (ms counter width = $clog2(max(HOLD_MS, REPEAT_MS)+1)).
- Sub-module ms_tick_gen: prescaler counting 0..MS_CYC-1 with synchronous clear, emits one-cycle tick on terminal count; instantiated once.

## Test plan
Bench uses CLK_FREQ=100000, HOLD_MS=5, REPEAT_MS=2 (MS_CYC=100, HOLD_CYC=500, REPEAT_CYC=200), 10 ns clock.
- Short press: level high 300 cycles → press at cycle+1, release 300 cycles later, held/repeat never assert.
- Long hold: level high 1000 cycles → held at +500, repeats at +500, +700, +900, repeat_count=3, release clears held.
- Race: level falls exactly at cycle 500 of hold → release pulses, held and repeat stay 0.
- Saturation: hold level ≥51,500 cycles → repeat_count reaches 255 and stays 255; next press clears to 0.
- Reset mid-hold: assert reset_n=0 while held=1 → all outputs 0 asynchronously; release reset with level=1 → press pulse one cycle later.
- Without BUTTON_EVENTS_REPEAT_EN: 1000-cycle hold → held at +500, repeat and repeat_count remain 0.
